// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-channel round-robin grant arbiter driving a 2:1 mux select
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       s,
  output logic       busy,
  output logic [7:0] sw_cnt
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  localparam logic [7:0] LIM = 8'(MAX_HOLD - 1);
  state_t     state, nxt, flip;
  logic [7:0] hold_cnt;
  logic       last, own, oth, at_lim;
  // next-state: ties in IDLE go to the channel not served last; a grant is kept
  // while its request stays high, unless the other side waits and the hold limit hit
  always_comb begin
    at_lim = hold_cnt == LIM;
    own = (state == G1) ? req1 : req0;
    oth = (state == G1) ? req0 : req1;
    flip = (state == G1) ? G0 : G1;
    nxt = state;
    if (state == IDLE)
      nxt = (req0 && req1) ? (last ? G0 : G1) : req0 ? G0 : req1 ? G1 : IDLE;
    else
      nxt = (own && !(oth && at_lim)) ? state : (oth ? flip : IDLE);
  end
  // state, registered grants/select, hold counter and handover counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      s <= 1'b0;
      hold_cnt <= '0;
      sw_cnt <= '0;
      last <= 1'b1;
    end else begin
      state <= nxt;
      gnt0 <= nxt == G0;
      gnt1 <= nxt == G1;
      if (nxt != IDLE) s <= nxt == G1;
      if (nxt != IDLE && nxt != state) last <= nxt == G1;
      hold_cnt <= (nxt != state || nxt == IDLE) ? '0 : at_lim ? hold_cnt : hold_cnt + 8'd1;
      if (state != IDLE && nxt != IDLE && nxt != state) sw_cnt <= sw_cnt + 8'd1;
    end
  end
  assign busy = gnt0 | gnt1;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed checks of grant sequencing, select hold and counters
module tb_mux_sel_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0;
  logic a_g0, a_g1, a_s, a_busy, b_g0, b_g1, b_s, b_busy;
  logic [7:0] a_sw, b_sw;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(4)) u4 (.clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(a_g0), .gnt1(a_g1), .s(a_s), .busy(a_busy), .sw_cnt(a_sw));
  mux_sel_arbiter #(.MAX_HOLD(2)) u2 (.clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .gnt0(b_g0), .gnt1(b_g1), .s(b_s), .busy(b_busy), .sw_cnt(b_sw));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ev(input logic g0, input logic g1, input logic sel, input logic [7:0] sw);
    return {g0, g1, sel, g0 | g1, sw};
  endfunction

  // grants must never overlap on either instance
  always @(negedge clk) begin
    tests++;
    assert (!(a_g0 && a_g1) && !(b_g0 && b_g1)) else begin
      fails++;
      $error("FAIL overlap observed=%b%b/%b%b expected=no double grant", a_g0, a_g1, b_g0, b_g1);
    end
  end

  initial begin
    // reset with requests high: ignored
    req0 = 1; req1 = 1;
    tick(); tick();
    chk("reset4", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 0, 0, 8'd0));
    chk("reset2", {b_g0, b_g1, b_s, b_busy, b_sw}, ev(0, 0, 0, 8'd0));
    req0 = 0; req1 = 0; rst_n = 1;
    tick();
    chk("idle_after_rel", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 0, 0, 8'd0));
    // both held: alternate every MAX_HOLD cycles, channel 0 wins the first tie
    req0 = 1; req1 = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("alt4_k%0d", k), {a_g0, a_g1, a_s, a_busy, a_sw},
          ev(((k / 4) % 2) == 0, ((k / 4) % 2) == 1, ((k / 4) % 2) == 1, 8'(k / 4)));
      chk($sformatf("alt2_k%0d", k), {b_g0, b_g1, b_s, b_busy, b_sw},
          ev(((k / 2) % 2) == 0, ((k / 2) % 2) == 1, ((k / 2) % 2) == 1, 8'(k / 2)));
    end
    // both drop from G1: IDLE with select held at 1
    req0 = 0; req1 = 0;
    tick();
    chk("idle_hold_s4", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 0, 1, 8'd3));
    chk("idle_hold_s2", {b_g0, b_g1, b_s, b_busy, b_sw}, ev(0, 0, 1, 8'd7));
    // fresh reset, then req1 pulsed for 3 cycles
    rst_n = 0;
    tick();
    chk("reset_again", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 0, 0, 8'd0));
    rst_n = 1; req1 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("pulse1_k%0d", k), {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 1, 1, 8'd0));
    end
    req1 = 0;
    tick();
    chk("pulse1_idle", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 0, 1, 8'd0));
    // req0 alone for 20 cycles: no handover
    req0 = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("hold0_k%0d", k), {a_g0, a_g1, a_s, a_busy, a_sw}, ev(1, 0, 0, 8'd0));
    end
    req1 = 1;
    tick();
    chk("late_req1", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 1, 1, 8'd1));
    // drop req1 in G1 with req0 high: direct handover
    req1 = 0;
    tick();
    chk("drop_req1", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(1, 0, 0, 8'd2));
    // via IDLE, a tie goes to channel 1 since channel 0 was served last
    req0 = 0;
    tick();
    chk("idle_mid", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 0, 0, 8'd2));
    req0 = 1; req1 = 1;
    tick();
    chk("tie_to_1", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 1, 1, 8'd2));
    for (int k = 0; k < 3; k++) tick();
    chk("g1_at_limit", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 1, 1, 8'd2));
    // request drops on the limit cycle: req-drop rule gives G0
    req1 = 0;
    tick();
    chk("drop_at_limit", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(1, 0, 0, 8'd3));
    // reach sw_cnt=255 in G1, then reset mid-grant
    rst_n = 0;
    tick();
    rst_n = 1; req0 = 1; req1 = 1;
    for (int k = 0; k <= 1020; k++) begin
      tick();
      if (k == 1020) chk("sw255_g1", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 1, 1, 8'd255));
    end
    rst_n = 0;
    tick();
    chk("rst_mid_g1", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 0, 0, 8'd0));
    tick();
    chk("rst_ignores_req", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 0, 0, 8'd0));
    // 256 swaps from zero wrap the counter
    rst_n = 1;
    for (int k = 0; k <= 1024; k++) begin
      tick();
      if (k == 1023) chk("pre_wrap", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(0, 1, 1, 8'd255));
      if (k == 1024) chk("wrap", {a_g0, a_g1, a_s, a_busy, a_sw}, ev(1, 0, 0, 8'd0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
